// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared arbiter modes, states and id width helper
package arbiter_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // A single requester still gets a one-bit id so ports never collapse to zero width.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arbiter_interface.sv
// rtl/arbiter_interface.sv - bundle of arbiter signals with stimulus, design and observer views
interface arbiter_interface
    import arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input logic clk
);

    logic                            rst;
    logic [NUM_REQ-1:0]              request;
    logic [NUM_REQ-1:0]              grant;
    logic                            grant_valid;
    logic [id_width(NUM_REQ)-1:0]    grant_id;

    modport TEST (
        input  clk,
        input  grant,
        input  grant_valid,
        input  grant_id,
        output rst,
        output request
    );

    modport DUT (
        input  clk,
        input  rst,
        input  request,
        output grant,
        output grant_valid,
        output grant_id
    );

    modport MONITOR (
        input clk,
        input rst,
        input request,
        input grant,
        input grant_valid,
        input grant_id
    );

endinterface

// File: rtl/arbiter_prio_pick.sv
// rtl/arbiter_prio_pick.sv - combinational picker: first set request bit at or after start, wrapping
module arbiter_prio_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          found
);

    int pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(start) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && req[IW'(pos)]) begin
                found              = 1'b1;
                idx                = IW'(pos);
                onehot[IW'(pos)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbiter_rr_n.sv
// rtl/arbiter_rr_n.sv - N-way fixed/round-robin arbiter with bounded tenure and registered one-hot grant
module arbiter_rr_n
    import arbiter_pkg::*;
#(
    parameter int        NUM_REQ  = 4,
    parameter arb_mode_e MODE     = ARB_RR,
    parameter int        MAX_HOLD = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            request,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          grant_valid,
    output logic [id_width(NUM_REQ)-1:0]  grant_id
);

    localparam int              IW        = id_width(NUM_REQ);
    localparam int              HW        = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IW-1:0]   LAST_INIT = IW'(NUM_REQ - 1);

    arb_state_e          state_q,   state_d;
    logic [NUM_REQ-1:0]  grant_q,   grant_d;
    logic [IW-1:0]       grant_id_q, grant_id_d;
    logic [HW-1:0]       hold_q,    hold_d;
    logic [IW-1:0]       last_id_q, last_id_d;

    logic [NUM_REQ-1:0]  pick_req;
    logic [IW-1:0]       pick_start;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IW-1:0]       pick_idx;
    logic                pick_found;
    logic                owner_req;
    logic                new_tenure;
    logic                go_idle;

    // While busy the current owner is masked out, so any pick is a hand-over to someone else.
    assign pick_req  = (state_q == IDLE) ? request : (request & ~grant_q);
    assign owner_req = |(request & grant_q);

    always_comb begin
        pick_start = '0;
        if (MODE == ARB_RR && last_id_q != LAST_INIT) begin
            pick_start = last_id_q + IW'(1);
        end
    end

    arbiter_prio_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req    (pick_req),
        .start  (pick_start),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        hold_d     = hold_q;
        last_id_d  = last_id_q;
        new_tenure = 1'b0;
        go_idle    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    new_tenure = 1'b1;
                end else begin
                    go_idle = 1'b1;
                end
            end
            BUSY: begin
                if (!owner_req) begin
                    if (pick_found) begin
                        new_tenure = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HW'(1);
                end else if (pick_found) begin
                    new_tenure = 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (new_tenure) begin
            state_d    = BUSY;
            grant_d    = pick_onehot;
            grant_id_d = pick_idx;
            hold_d     = '0;
            last_id_d  = pick_idx;
        end else if (go_idle) begin
            state_d    = IDLE;
            grant_d    = '0;
            grant_id_d = '0;
            hold_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            hold_q     <= '0;
            last_id_q  <= LAST_INIT;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            hold_q     <= hold_d;
            last_id_q  <= last_id_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_arbiter_rr_n.sv
// tb/tb_arbiter_rr_n.sv - five arbiter configurations driven in parallel against a tenure-level model
module tb_arbiter_rr_n
    import arbiter_pkg::*;
;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req;

    logic [3:0] g0, g1, g2;
    logic [1:0] i0, i1, i2;
    logic       v0, v1, v2, v3, v4;
    logic [0:0] g3, i3;
    logic [4:0] g4;
    logic [2:0] i4;

    logic [4:0] obs_g  [5];
    logic [2:0] obs_id [5];
    logic       obs_v  [5];

    int n_tests = 0;
    int n_fail  = 0;

    // Per-instance configuration and tenure-level model state (owner -1 means idle).
    int n_of  [5] = '{4, 4, 4, 1, 5};
    int mh_of [5] = '{1, 8, 8, 8, 3};
    bit rr_of [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int m_owner  [5];
    int m_cycles [5];
    int m_last   [5];

    always #5 clk = ~clk;

    arbiter_rr_n #(.NUM_REQ(4), .MODE(ARB_RR), .MAX_HOLD(1)) u0 (
        .clk(clk), .rst(rst), .request(req[3:0]), .grant(g0), .grant_valid(v0), .grant_id(i0));
    arbiter_rr_n #(.NUM_REQ(4), .MODE(ARB_FIXED), .MAX_HOLD(8)) u1 (
        .clk(clk), .rst(rst), .request(req[3:0]), .grant(g1), .grant_valid(v1), .grant_id(i1));
    arbiter_rr_n #(.NUM_REQ(4), .MODE(ARB_RR), .MAX_HOLD(8)) u2 (
        .clk(clk), .rst(rst), .request(req[3:0]), .grant(g2), .grant_valid(v2), .grant_id(i2));
    arbiter_rr_n #(.NUM_REQ(1), .MODE(ARB_RR), .MAX_HOLD(8)) u3 (
        .clk(clk), .rst(rst), .request(req[0:0]), .grant(g3), .grant_valid(v3), .grant_id(i3));
    arbiter_rr_n #(.NUM_REQ(5), .MODE(ARB_RR), .MAX_HOLD(3)) u4 (
        .clk(clk), .rst(rst), .request(req), .grant(g4), .grant_valid(v4), .grant_id(i4));

    assign obs_g[0] = {1'b0, g0};
    assign obs_g[1] = {1'b0, g1};
    assign obs_g[2] = {1'b0, g2};
    assign obs_g[3] = {4'b0, g3};
    assign obs_g[4] = g4;
    assign obs_id[0] = {1'b0, i0};
    assign obs_id[1] = {1'b0, i1};
    assign obs_id[2] = {1'b0, i2};
    assign obs_id[3] = {2'b0, i3};
    assign obs_id[4] = i4;
    assign obs_v[0] = v0;
    assign obs_v[1] = v1;
    assign obs_v[2] = v2;
    assign obs_v[3] = v3;
    assign obs_v[4] = v4;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            m_owner[k]  = -1;
            m_cycles[k] = 0;
            m_last[k]   = n_of[k] - 1;
        end
    endtask

    task automatic model_step(input logic [4:0] r);
        for (int k = 0; k < 5; k++) begin
            int n      = n_of[k];
            bit others = 1'b0;
            int w      = -1;
            int start;
            for (int j = 0; j < n; j++) begin
                if (r[3'(j)] && j != m_owner[k]) others = 1'b1;
            end
            if (m_owner[k] >= 0 && r[3'(m_owner[k])] && (m_cycles[k] < mh_of[k] || !others)) begin
                if (m_cycles[k] < mh_of[k]) m_cycles[k]++;
            end else begin
                start = rr_of[k] ? (m_last[k] + 1) % n : 0;
                for (int j = 0; j < n; j++) begin
                    int c = (start + j) % n;
                    if (w < 0 && r[3'(c)] && c != m_owner[k]) w = c;
                end
                if (w >= 0) begin
                    m_owner[k]  = w;
                    m_cycles[k] = 1;
                    m_last[k]   = w;
                end else begin
                    m_owner[k]  = -1;
                    m_cycles[k] = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 5; k++) begin
            int eg = (m_owner[k] < 0) ? 0 : (1 << m_owner[k]);
            check($sformatf("%s.grant%0d", tag, k), int'(obs_g[k]), eg);
            check($sformatf("%s.valid%0d", tag, k), int'(obs_v[k]), (m_owner[k] >= 0) ? 1 : 0);
            check($sformatf("%s.id%0d", tag, k), int'(obs_id[k]), (m_owner[k] < 0) ? 0 : m_owner[k]);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step(req);
        #1;
        check_all(tag);
    endtask

    // Called just after an edge: asserts reset mid-cycle and releases it well before the next edge.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int seq030 [5] = '{0, 1, 2, 3, 0};
        logic prev0;

        rst = 1'b1;
        req = 5'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        for (int c = 0; c < 5; c++) begin
            cycle("idle");
            check("idle.grant_u2", int'(g2), 0);
        end

        pulse_reset("rst030");
        req = 5'b01111;
        for (int c = 0; c < 5; c++) begin
            cycle("rr_mh1");
            check($sformatf("rr_mh1.seq%0d", c), int'(i0), seq030[c]);
        end

        pulse_reset("rst031");
        req = 5'b01010;
        for (int c = 0; c < 17; c++) begin
            cycle("fixed");
            check($sformatf("fixed.grant_c%0d", c), int'(g1), (c < 8) ? 2 : (c < 16) ? 8 : 2);
        end

        pulse_reset("rst032");
        req = 5'b00100;
        for (int c = 0; c < 20; c++) begin
            cycle("solo");
            check($sformatf("solo.grant_c%0d", c), int'(g2), 4);
        end

        pulse_reset("rst033");
        req = 5'b00010;
        cycle("drop.a");
        check("drop.owner1", int'(g2), 2);
        req = 5'b01010;
        cycle("drop.b");
        check("drop.keep1", int'(g2), 2);
        req = 5'b01000;
        cycle("drop.c");
        check("drop.handover", int'(g2), 8);

        pulse_reset("rst034a");
        req = 5'b00100;
        cycle("rst034.a");
        cycle("rst034.b");
        check("rst034.pre", int'(g2), 4);
        pulse_reset("rst034.mid");
        check("rst034.cleared", int'(g2), 0);
        req = 5'b01111;
        cycle("rst034.c");
        check("rst034.first_u0", int'(i0), 0);
        check("rst034.first_u1", int'(i1), 0);
        check("rst034.first_u2", int'(i2), 0);

        prev0 = req[0];
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 5'($urandom_range(0, 31));
            end else if ($urandom_range(0, 3) == 0) begin
                req = req & ~5'(1 << $urandom_range(0, 4));
            end
            prev0 = req[0];
            cycle("rand");
            check("rand.single_follow", int'(g3), int'(prev0));
            if (c == 200) pulse_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arbiter_rr_n.md
ARBITER_RR_N -- requirements
Module: arbiter_rr_n

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (legal 1..16).
REQ-002 Parameter MODE, default ARB_RR, arbitration mode (ARB_FIXED or ARB_RR).
REQ-003 Parameter MAX_HOLD, default 8, max consecutive grant cycles per tenure when others wait (legal 1..255).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-high.
REQ-006 request  input  NUM_REQ  per-requester request, bit i = requester i.
REQ-007 grant  output  NUM_REQ  registered one-hot grant, all-zero when idle.
REQ-008 grant_valid  output  1  high when any grant bit is high.
REQ-009 grant_id  output  max(1,$clog2(NUM_REQ))  index of granted requester, 0 when idle.

Function
REQ-010 States IDLE and BUSY only, held in one state register.
REQ-011 IDLE: if request nonzero, the next edge grants the winner and enters BUSY; otherwise stays IDLE with grant=0.
REQ-012 Latency: request asserted before edge k -> grant visible after edge k (one cycle).
REQ-013 ARB_FIXED winner = lowest asserted index.
REQ-014 ARB_RR winner = first asserted index searching upward from (last_id+1) mod NUM_REQ, wrapping.
REQ-015 last_id updates only on the edge a new tenure starts.
REQ-016 BUSY, owner request high, hold_cnt < MAX_HOLD-1: grant held, hold_cnt increments.
REQ-017 BUSY, hold_cnt = MAX_HOLD-1 and another request pending: re-arbitrate excluding owner; new grant on the same edge, hold_cnt=0.
REQ-018 BUSY, hold_cnt = MAX_HOLD-1 and no other request: owner keeps grant, hold_cnt saturates at MAX_HOLD-1.
REQ-019 BUSY, owner request low: same edge grants next winner (per mode) if any other request, else returns to IDLE with grant=0; no dead cycle.
REQ-020 Owner drops request in the same cycle its hold expires: REQ-019 applies.
REQ-021 grant never has more than one bit set; grant bit i never high while request[i] low for two consecutive cycles.
REQ-022 NUM_REQ=1: grant[0] follows request[0] delayed one cycle; hold limit has no effect.
REQ-023 hold_cnt width $clog2(MAX_HOLD+1); no overflow wrap.

Reset
REQ-024 rst high immediately clears grant, grant_valid, grant_id, hold_cnt, forces IDLE, sets last_id = NUM_REQ-1 (so requester 0 has first RR priority).
REQ-025 Reset mid-tenure drops grant asynchronously; first arbitration after release follows REQ-011/REQ-024.

Structure
REQ-026 Package arbiter_pkg holds arb_mode_e (ARB_FIXED, ARB_RR) and arb_state_e (IDLE, BUSY).
REQ-027 Sub-module arbiter_prio_pick: combinational rotating-priority picker (inputs request mask, start index; outputs one-hot and index, found flag); arbiter_rr_n instantiates one.
REQ-028 arbiter_interface gains NUM_REQ parameter; modports TEST, DUT, MONITOR unchanged in direction.

Verification
REQ-029 Reset release, request=4'b0000 for 5 cycles -> grant=0, grant_valid=0, grant_id=0 throughout.
REQ-030 ARB_RR, request=4'b1111 held, MAX_HOLD=1 -> grant_id sequence 0,1,2,3,0 on consecutive cycles.
REQ-031 ARB_FIXED, request=4'b1010 held, MAX_HOLD=8 -> grant=4'b0010 for 8 cycles, then 4'b1000 for 8 cycles, then 4'b0010.
REQ-032 ARB_RR, only request[2] high for 20 cycles -> grant=4'b0100 continuously, hold_cnt saturates, no gap.
REQ-033 Owner 1 drops request while request[3] high -> next cycle grant=4'b1000 with no idle cycle.
REQ-034 rst pulsed while grant=4'b0100 -> grant=0 immediately; after release, request=4'b1111 -> first grant_id=0.
